// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Types and constants shared by the UART transmit arbiter and the
//   uart_full_duplex core.
//   - arb_state_t : transmit arbiter FSM states
//   - UART_DATA_W : byte width of the UART data path
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin winner selection.
//   The request vector is rotated so that the source just after the last grant
//   lands on bit 0, the lowest set bit is found, and its position is rotated
//   back into an absolute source index.
// Ports
//   req        in  N   request vector
//   last_grant in  IW  index of the previously granted source
//   any        out 1   at least one request is set
//   winner     out IW  granted index (valid only when any=1)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          any,
    output logic [IW-1:0] winner
);

    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] first;
    logic [IW:0]   back_raw;

    // rot[gi] = req[(gi + last_grant + 1) mod N]; the sum never exceeds 2N-1,
    // so a single conditional subtract implements the modulo.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            localparam logic [IW:0] OFS = (IW + 1)'(gi + 1);
            logic [IW:0] raw;
            logic [IW:0] idx;
            assign raw    = OFS + {1'b0, last_grant};
            assign idx    = (raw >= N_W) ? (raw - N_W) : raw;
            assign rot[gi] = req[idx[IW-1:0]];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins (scan downward so the
    // lowest index is written last).
    always_comb begin
        any   = 1'b0;
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any   = 1'b1;
                first = IW'(i);
            end
        end
    end

    // Undo the rotation: winner = (first + last_grant + 1) mod N.
    assign back_raw = {1'b0, first} + {1'b0, last_grant} + (IW + 1)'(1);
    assign winner   = (back_raw >= N_W) ? IW'(back_raw - N_W) : IW'(back_raw);

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte sources. Sources offer a
//   byte with valid/ready; a round-robin grant latches the byte, pulses
//   req_ready and uart_tx_start, then follows uart_tx_busy until the frame is
//   on the line. If the UART never goes busy within BUSY_TIMEOUT cycles the
//   byte is dropped and timeout_err pulses.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   req_valid      per-source byte offered
//   req_data       source i byte at [i*DATA_W +: DATA_W]
//   req_ready      one-hot, one-cycle accept pulse
//   uart_tx_start  one-cycle start pulse to the UART
//   uart_tx_data   byte to the UART, held from START until the frame ends
//   uart_tx_busy   UART transmitter busy
//   grant_id       index of the current / last granted source
//   arb_busy       high whenever the FSM is not idle
//   timeout_err    one-cycle pulse: the UART never reported busy
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_tx_start,
    output logic [DATA_W-1:0]             uart_tx_data,
    input  logic                          uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    localparam logic [IW-1:0]      LAST_RESET = IW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);

    arb_state_t        state_reg;
    logic [IW-1:0]     last_grant_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              arb_any;
    logic [IW-1:0]     arb_winner;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .any        (arb_any),
        .winner     (arb_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= LAST_RESET;  // source 0 has top priority
            cnt_reg        <= '0;
            req_ready      <= '0;
            uart_tx_start  <= 1'b0;
            uart_tx_data   <= '0;
            grant_id       <= '0;
            arb_busy       <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            req_ready     <= '0;
            uart_tx_start <= 1'b0;
            timeout_err   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // A busy UART blocks granting, so no byte is accepted
                    // that could not be started immediately.
                    if (arb_any && !uart_tx_busy) begin
                        uart_tx_data   <= data_arr[arb_winner];
                        grant_id       <= arb_winner;
                        last_grant_reg <= arb_winner;
                        req_ready      <= ONE_HOT0 << arb_winner;
                        uart_tx_start  <= 1'b1;
                        arb_busy       <= 1'b1;
                        state_reg      <= START;
                    end
                end

                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Byte is dropped; the pointer already moved past
                        // this source at grant time.
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        arb_busy  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    arb_busy  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with a behavioural UART stub that goes
//   busy for FRAME cycles after each start pulse, or can be pinned low/high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 16;
    localparam int FRAME        = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      uart_tx_start;
    logic [DATA_W-1:0]         uart_tx_data;
    logic                      uart_tx_busy = 1'b0;
    logic [1:0]                grant_id;
    logic                      arb_busy;
    logic                      timeout_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    // UART stub state: mode 0 = follows start, 1 = busy pinned 0, 2 = pinned 1
    int           stub_mode = 0;
    int           busy_left = 0;
    int           to_cnt    = 0;
    logic [7:0]   log_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_busy  (uart_tx_busy),
        .grant_id      (grant_id),
        .arb_busy      (arb_busy),
        .timeout_err   (timeout_err)
    );

    always #10 clk = ~clk;  // 50 MHz

    always @(negedge clk) begin
        if (uart_tx_start) log_q.push_back(uart_tx_data);
        if (timeout_err) to_cnt++;
        case (stub_mode)
            0: begin
                if (uart_tx_start) busy_left = FRAME;
                if (busy_left > 0) begin
                    uart_tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    uart_tx_busy = 1'b0;
                end
            end
            1: begin busy_left = 0; uart_tx_busy = 1'b0; end
            default: begin busy_left = 0; uart_tx_busy = 1'b1; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until req_ready shows up; lands in the cycle of the pulse.
    task automatic wait_grant(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (req_ready != '0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({tag, "_grant_wait"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!arb_busy) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({tag, "_idle_wait"}, 32'd0, 32'd1);
    endtask

    initial begin
        int c;
        bit bad;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_start", 32'(uart_tx_start), 32'h0);
        check("rst_busy",  32'(arb_busy), 32'h0);
        check("rst_gid",   32'(grant_id), 32'h0);
        rst = 1'b0;
        step();

        // ---------------- all valid: order 0,1,2,3 ----------------
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("all%0d", k));
            check($sformatf("all%0d_gid", k),   32'(grant_id), 32'(k));
            check($sformatf("all%0d_ready", k), 32'(req_ready), 32'(1 << k));
            check($sformatf("all%0d_data", k),  32'(uart_tx_data), 32'((k + 1) * 8'h11));
            req_valid[k] = 1'b0;
        end
        wait_idle("all");
        check("all_log_n", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            check($sformatf("all_log%0d", k), 32'(log_q[k]), 32'((k + 1) * 8'h11));

        // ---------------- wrap: grant 2, then 3 before 0 ----------------
        req_data  = 32'hD3_77_00_A0;
        req_valid = 4'b0100;
        wait_grant("wrap2");
        check("wrap2_gid", 32'(grant_id), 32'd2);
        req_valid = 4'b0000;
        wait_idle("wrap2");
        req_valid = 4'b1001;
        wait_grant("wrap3");
        check("wrap3_gid",  32'(grant_id), 32'd3);
        check("wrap3_data", 32'(uart_tx_data), 32'hD3);
        req_valid[3] = 1'b0;
        wait_grant("wrap0");
        check("wrap0_gid",  32'(grant_id), 32'd0);
        check("wrap0_data", 32'(uart_tx_data), 32'hA0);
        req_valid = 4'b0000;
        wait_idle("wrap");

        // ---------------- single source, 1-cycle latency ----------------
        req_data  = 32'h0000005A;
        req_valid = 4'b0001;
        step();
        check("single_ready", 32'(req_ready), 32'h1);
        check("single_start", 32'(uart_tx_start), 32'h1);
        check("single_data",  32'(uart_tx_data), 32'h5A);
        req_valid = 4'b0000;
        step();
        check("single_pulse", 32'(uart_tx_start), 32'h0);
        wait_idle("single");
        check("single_log", 32'(log_q[log_q.size()-1]), 32'h5A);
        check("single_no_to", 32'(to_cnt), 32'd0);

        // ---------------- timeout with busy pinned low ----------------
        stub_mode = 1;
        req_data  = 32'h00005B00;
        req_valid = 4'b0010;
        step();
        check("to_start", 32'(uart_tx_start), 32'h1);
        req_valid = 4'b0000;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (timeout_err) begin
                c = i;
                break;
            end
        end
        check("to_delay", 32'(c), 32'(BUSY_TIMEOUT + 1));
        check("to_idle",  32'(arb_busy), 32'h0);
        check("to_gid",   32'(grant_id), 32'd1);
        step();
        check("to_pulse", 32'(timeout_err), 32'h0);
        check("to_count", 32'(to_cnt), 32'd1);
        stub_mode = 0;
        step();

        // ---------------- busy pinned high in IDLE ----------------
        stub_mode = 2;
        step();
        req_data  = 32'h0000003C;
        req_valid = 4'b0001;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (req_ready != '0 || uart_tx_start) bad = 1;
        end
        check("hold_no_grant", 32'(bad), 32'h0);
        stub_mode = 0;   // busy drops at the next falling edge
        step();
        check("hold_release_ready", 32'(req_ready), 32'h1);
        check("hold_release_data",  32'(uart_tx_data), 32'h3C);
        req_valid = 4'b0000;
        wait_idle("hold");

        // ---------------- reset during WAIT_DONE ----------------
        req_data  = 32'h00990000;
        req_valid = 4'b0100;
        wait_grant("mid");
        req_valid = 4'b0000;
        step(); step();
        check("mid_in_frame", 32'(arb_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(arb_busy), 32'h0);
        check("mid_rst_gid",  32'(grant_id), 32'h0);
        check("mid_rst_data", 32'(uart_tx_data), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 40 && uart_tx_busy; i++) step();
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        wait_grant("post");
        check("post_gid",  32'(grant_id), 32'd0);
        check("post_data", 32'(uart_tx_data), 32'h11);
        req_valid = 4'b0000;
        wait_idle("post");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
